serial_adder_ctrl: RTL

Bit-serial WIDTH-bit adder built around the team's one-bit full adder (`myFullAdder`, ports X, Y, cin, sum, cout), which it instantiates exactly once.
- Accepts two operands and a carry-in on a start pulse.
- Feeds one bit pair per clock, LSB first, into the full adder and registers the carry between cycles.
- Assembles the result and presents a registered WIDTH-bit sum plus final carry-out, with a one-cycle done pulse.
- Sits directly upstream of the full adder: it is the sequential stage that drives it.

---
 rtl/serial_adder_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial WIDTH-bit adder driving a single one-bit
// full adder (myFullAdder), one bit pair per clock, LSB first.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, adds input `sub`; with sub=1 the block computes a - b
//   (two's complement: b inverted, carry-in forced to 1) and cout=1 means
//   no borrow.
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous active-high reset
//   start  in   1      request, sampled only in IDLE or DONE
//   a, b   in   WIDTH  operands, captured on the accepted start edge
//   cin    in   1      carry-in, captured on the accepted start edge
//   sub    in   1      (SERIAL_ADDER_SUB_EN only) subtract select
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle completion pulse
//   sum    out  WIDTH  registered result, held between operations
//   cout   out  1      registered final carry, held between operations

module myFullAdder (
  input  logic X,
  input  logic Y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = X ^ Y ^ cin;
  assign cout = (X & Y) | (cin & (X ^ Y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               last;
  logic               fa_sum, fa_cout;
  logic [WIDTH-1:0]   sum_sh_nxt;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  myFullAdder u_fa (
    .X    (a_sh[0]),
    .Y    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign accept     = start && (state == IDLE || state == DONE);
  assign last       = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign sum_sh_nxt = {fa_sum, sum_sh[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; the incoming cin is ignored in that mode.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last)  next_state = DONE;
      DONE:    next_state = start ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial shifting, result update on the
  // completion edge only.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b_load;
      sum_sh <= '0;
      carry  <= carry_load;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      sum_sh <= sum_sh_nxt;
      carry  <= fa_cout;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        sum  <= sum_sh_nxt;
        cout <= fa_cout;
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
